// File: rtl/mvau_defn.sv
// Shared definitions for the binary MVU processing element: folding factors,
// counter widths and the accumulate/output sequencer state.
package mvau_defn;

    localparam int unsigned MATRIX_W = 32;
    localparam int unsigned MATRIX_H = 4;
    localparam int unsigned SIMD     = 8;
    localparam int unsigned PE       = 2;
    localparam int unsigned TDSTI    = 16;

    localparam int unsigned SF = MATRIX_W / SIMD;
    localparam int unsigned NF = MATRIX_H / PE;

    // Width that can hold 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 32'd1);
    endfunction

    localparam int unsigned SF_CNT_W = $clog2(SF + 1);
    localparam int unsigned NF_CNT_W = $clog2(NF + 1);

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_e;

endpackage

// File: rtl/mvu_pe_popcount_acc_ctrl.sv
// Folds SF popcount beats into one dot product per output row and streams the
// rows out on valid/ready, flagging the last of NF rows in each matrix.
module mvu_pe_popcount_acc_ctrl #(
    parameter int unsigned SF    = mvau_defn::SF,
    parameter int unsigned NF    = mvau_defn::NF,
    parameter int unsigned TDstI = mvau_defn::TDSTI
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             in_v,
    input  logic [TDstI-1:0] in_popcount,
    output logic             in_rdy,
    output logic             out_v,
    output logic [TDstI-1:0] out_acc,
    output logic             out_last,
    input  logic             out_rdy
);
    import mvau_defn::state_e;
    import mvau_defn::ACC;
    import mvau_defn::OUT;
    import mvau_defn::cnt_w;

    localparam int unsigned SF_W = cnt_w(SF);
    localparam int unsigned NF_W = cnt_w(NF);

    state_e             state_q,  state_d;
    logic [SF_W-1:0]    sf_cnt_q, sf_cnt_d;
    logic [NF_W-1:0]    nf_cnt_q, nf_cnt_d;
    logic [TDstI-1:0]   acc_q,    acc_d;
    logic               accept_s;
    logic               emit_s;
    logic               sf_last_s;
    logic               nf_last_s;

    assign sf_last_s = (sf_cnt_q == SF_W'(SF - 1));
    assign nf_last_s = (nf_cnt_q == NF_W'(NF - 1));

    assign out_v    = (state_q == OUT);
    assign out_acc  = acc_q;
    assign out_last = out_v && nf_last_s;
    // While a result waits, a new beat may only enter alongside its emission.
    assign in_rdy   = (state_q == ACC) ? 1'b1 : out_rdy;

    assign accept_s = in_v && in_rdy;
    assign emit_s   = out_v && out_rdy;

    // Next-state, fold counter, row counter and accumulator update.
    always_comb begin
        state_d  = state_q;
        sf_cnt_d = sf_cnt_q;
        nf_cnt_d = nf_cnt_q;
        acc_d    = acc_q;
        case (state_q)
            ACC: begin
                if (accept_s) begin
                    acc_d = (sf_cnt_q == SF_W'(0)) ? in_popcount : acc_q + in_popcount;
                    if (sf_last_s) begin
                        sf_cnt_d = SF_W'(0);
                        state_d  = OUT;
                    end else begin
                        sf_cnt_d = sf_cnt_q + SF_W'(1);
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            OUT: begin
                if (emit_s) begin
                    nf_cnt_d = nf_last_s ? NF_W'(0) : nf_cnt_q + NF_W'(1);
                    if (accept_s) begin
                        acc_d = in_popcount;
                        if (SF == 1) begin
                            sf_cnt_d = SF_W'(0);
                            state_d  = OUT;
                        end else begin
                            sf_cnt_d = SF_W'(1);
                            state_d  = ACC;
                        end
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d  = ACC;
                sf_cnt_d = SF_W'(0);
                nf_cnt_d = NF_W'(0);
                acc_d    = '0;
            end
        endcase
    end

    // State, counters and accumulator registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ACC;
            sf_cnt_q <= '0;
            nf_cnt_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            sf_cnt_q <= sf_cnt_d;
            nf_cnt_q <= nf_cnt_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: tb/tb_mvu_pe_popcount_acc_ctrl.sv
// Directed bench for the PE popcount accumulator: a default instance, a narrow
// accumulator instance for wrap-around, and an SF=1 streaming instance.
module tb_mvu_pe_popcount_acc_ctrl;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic        m_in_v, m_in_rdy, m_out_v, m_out_last, m_out_rdy;
    logic [15:0] m_pop, m_out_acc;
    logic        w_in_v, w_in_rdy, w_out_v, w_out_last, w_out_rdy;
    logic [3:0]  w_pop, w_out_acc;
    logic        s_in_v, s_in_rdy, s_out_v, s_out_last, s_out_rdy;
    logic [15:0] s_pop, s_out_acc;

    mvu_pe_popcount_acc_ctrl #(.SF(4), .NF(2), .TDstI(16)) u_main (
        .aclk(aclk), .aresetn(aresetn), .in_v(m_in_v), .in_popcount(m_pop),
        .in_rdy(m_in_rdy), .out_v(m_out_v), .out_acc(m_out_acc),
        .out_last(m_out_last), .out_rdy(m_out_rdy)
    );

    mvu_pe_popcount_acc_ctrl #(.SF(4), .NF(2), .TDstI(4)) u_wrap (
        .aclk(aclk), .aresetn(aresetn), .in_v(w_in_v), .in_popcount(w_pop),
        .in_rdy(w_in_rdy), .out_v(w_out_v), .out_acc(w_out_acc),
        .out_last(w_out_last), .out_rdy(w_out_rdy)
    );

    mvu_pe_popcount_acc_ctrl #(.SF(1), .NF(2), .TDstI(16)) u_sf1 (
        .aclk(aclk), .aresetn(aresetn), .in_v(s_in_v), .in_popcount(s_pop),
        .in_rdy(s_in_rdy), .out_v(s_out_v), .out_acc(s_out_acc),
        .out_last(s_out_last), .out_rdy(s_out_rdy)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic mbeat(input logic v, input logic [15:0] p, input logic r);
        m_in_v    = v;
        m_pop     = v ? p : 16'hxxxx;
        m_out_rdy = r;
        tick();
    endtask

    task automatic mrow(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d, input logic r);
        mbeat(1'b1, a, r);
        mbeat(1'b1, b, r);
        mbeat(1'b1, c, r);
        check_eq("row_not_early", {31'd0, m_out_v}, 32'd0);
        mbeat(1'b1, d, r);
    endtask

    initial begin
        logic        bv, br, e_out, e_in_rdy;
        logic [15:0] bp, e_sum;
        int unsigned e_cnt, e_nf, rows;

        aresetn = 1'b0;
        m_in_v = 1'b0; m_pop = 16'd0; m_out_rdy = 1'b1;
        w_in_v = 1'b0; w_pop = 4'd0;  w_out_rdy = 1'b1;
        s_in_v = 1'b0; s_pop = 16'd0; s_out_rdy = 1'b1;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();
        check_eq("rst_out_v",    {31'd0, m_out_v},    32'd0);
        check_eq("rst_out_last", {31'd0, m_out_last}, 32'd0);
        check_eq("rst_out_acc",  {16'd0, m_out_acc},  32'd0);
        check_eq("rst_in_rdy",   {31'd0, m_in_rdy},   32'd1);
        check_eq("rst_w_out_v",  {31'd0, w_out_v},    32'd0);
        check_eq("rst_s_out_v",  {31'd0, s_out_v},    32'd0);

        // Wrap-around: 4 x 15 = 60, modulo 16 = 12.
        for (int i = 0; i < 4; i++) begin
            w_in_v = 1'b1; w_pop = 4'd15;
            tick();
        end
        w_in_v = 1'b0; w_pop = 4'hx;
        check_eq("wrap_out_v",   {31'd0, w_out_v},   32'd1);
        check_eq("wrap_out_acc", {28'd0, w_out_acc}, 32'd12);
        tick();
        check_eq("wrap_emitted", {31'd0, w_out_v},   32'd0);

        // SF=1 streaming: each beat is one row, last on every second result.
        for (int k = 1; k <= 6; k++) begin
            s_in_v = 1'b1; s_pop = 16'(k);
            #1;
            check_eq("sf1_in_rdy", {31'd0, s_in_rdy}, 32'd1);
            tick();
            check_eq("sf1_out_v",    {31'd0, s_out_v},    32'd1);
            check_eq("sf1_out_acc",  {16'd0, s_out_acc},  32'(k));
            check_eq("sf1_out_last", {31'd0, s_out_last}, ((k % 2) == 0) ? 32'd1 : 32'd0);
        end
        s_in_v = 1'b0; s_pop = 16'hxxxx;
        tick();
        check_eq("sf1_drain", {31'd0, s_out_v}, 32'd0);

        // Basic rows and row-counter wrap.
        mrow(16'd3, 16'd5, 16'd0, 16'd7, 1'b1);
        check_eq("row1_out_v",   {31'd0, m_out_v},    32'd1);
        check_eq("row1_out_acc", {16'd0, m_out_acc},  32'd15);
        check_eq("row1_last",    {31'd0, m_out_last}, 32'd0);
        mbeat(1'b0, 16'd0, 1'b1);
        check_eq("row1_one_cycle", {31'd0, m_out_v}, 32'd0);
        mrow(16'd1, 16'd1, 16'd1, 16'd1, 1'b1);
        check_eq("row2_out_acc", {16'd0, m_out_acc},  32'd4);
        check_eq("row2_last",    {31'd0, m_out_last}, 32'd1);
        mbeat(1'b0, 16'd0, 1'b1);
        mrow(16'd2, 16'd0, 16'd0, 16'd1, 1'b1);
        check_eq("row3_out_acc", {16'd0, m_out_acc},  32'd3);
        check_eq("row3_last",    {31'd0, m_out_last}, 32'd0);
        mbeat(1'b0, 16'd0, 1'b1);

        // Backpressure: result held, extra beats refused, then emit+accept.
        mrow(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            m_in_v = 1'b1; m_pop = 16'd9; m_out_rdy = 1'b0;
            #1;
            check_eq("bp_in_rdy", {31'd0, m_in_rdy}, 32'd0);
            tick();
            check_eq("bp_out_v",    {31'd0, m_out_v},    32'd1);
            check_eq("bp_out_acc",  {16'd0, m_out_acc},  32'd10);
            check_eq("bp_out_last", {31'd0, m_out_last}, 32'd1);
        end
        m_in_v = 1'b1; m_pop = 16'd2; m_out_rdy = 1'b1;
        #1;
        check_eq("bp_release_in_rdy", {31'd0, m_in_rdy}, 32'd1);
        tick();
        check_eq("bp_emitted", {31'd0, m_out_v}, 32'd0);
        mbeat(1'b1, 16'd1, 1'b1);
        mbeat(1'b1, 16'd1, 1'b1);
        check_eq("bp_next_not_early", {31'd0, m_out_v}, 32'd0);
        mbeat(1'b1, 16'd1, 1'b1);
        check_eq("bp_next_out_v",   {31'd0, m_out_v},    32'd1);
        check_eq("bp_next_out_acc", {16'd0, m_out_acc},  32'd5);
        check_eq("bp_next_last",    {31'd0, m_out_last}, 32'd0);
        mbeat(1'b0, 16'd0, 1'b1);

        // Bubbles and random backpressure against a scoreboard.
        e_out = 1'b0; e_sum = 16'd0; e_cnt = 0; e_nf = 1; rows = 0;
        for (int cyc = 0; cyc < 400 && rows < 4; cyc++) begin
            bv = 1'($urandom_range(0, 1));
            br = 1'($urandom_range(0, 1));
            bp = 16'($urandom_range(0, 15));
            m_in_v = bv; m_pop = bv ? bp : 16'hxxxx; m_out_rdy = br;
            #1;
            e_in_rdy = !e_out || br;
            check_eq("bub_in_rdy", {31'd0, m_in_rdy}, {31'd0, e_in_rdy});
            if (e_out) begin
                if (br) begin
                    rows++;
                    e_nf  = (e_nf == 1) ? 0 : 1;
                    e_out = 1'b0;
                    if (bv) begin
                        e_sum = bp;
                        e_cnt = 1;
                    end else begin
                        e_cnt = 0;
                    end
                end
            end else if (bv) begin
                e_sum = (e_cnt == 0) ? bp : e_sum + bp;
                e_cnt++;
                if (e_cnt == 4) begin
                    e_cnt = 0;
                    e_out = 1'b1;
                end
            end
            tick();
            check_eq("bub_out_v", {31'd0, m_out_v}, {31'd0, e_out});
            if (e_out) begin
                check_eq("bub_out_acc",  {16'd0, m_out_acc},  {16'd0, e_sum});
                check_eq("bub_out_last", {31'd0, m_out_last}, (e_nf == 1) ? 32'd1 : 32'd0);
            end
        end
        check_eq("bub_rows_done", rows, 32'd4);

        // Reset mid-row: partial sum discarded.
        mbeat(1'b1, 16'd7, 1'b1);
        mbeat(1'b1, 16'd7, 1'b1);
        m_in_v = 1'b0; m_pop = 16'hxxxx;
        aresetn = 1'b0;
        #1;
        check_eq("rst_row_out_acc", {16'd0, m_out_acc}, 32'd0);
        check_eq("rst_row_in_rdy",  {31'd0, m_in_rdy},  32'd1);
        tick();
        aresetn = 1'b1;
        mrow(16'd2, 16'd2, 16'd2, 16'd2, 1'b0);
        check_eq("rst_row_fresh_v",   {31'd0, m_out_v},    32'd1);
        check_eq("rst_row_fresh_acc", {16'd0, m_out_acc},  32'd8);
        check_eq("rst_row_fresh_last",{31'd0, m_out_last}, 32'd0);

        // Reset while a result is stalled: out_v drops without a clock edge.
        mbeat(1'b0, 16'd0, 1'b0);
        check_eq("rst_out_held", {31'd0, m_out_v}, 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check_eq("rst_out_async_v",    {31'd0, m_out_v},    32'd0);
        check_eq("rst_out_async_last", {31'd0, m_out_last}, 32'd0);
        check_eq("rst_out_async_acc",  {16'd0, m_out_acc},  32'd0);
        tick();
        aresetn = 1'b1;
        mrow(16'd2, 16'd2, 16'd2, 16'd2, 1'b1);
        check_eq("rst_after_v",    {31'd0, m_out_v},    32'd1);
        check_eq("rst_after_acc",  {16'd0, m_out_acc},  32'd8);
        check_eq("rst_after_last", {31'd0, m_out_last}, 32'd0);
        mbeat(1'b0, 16'd0, 1'b1);
        check_eq("rst_after_emit", {31'd0, m_out_v}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
